idec_pipe: RTL and testbench

IDEC_PIPE -- requirements
Module: idec_pipe

---
 rtl/idec_pipe.sv | 163 ++++++++++++++++
 tb/tb_idec_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idec_pipe.sv
// Instruction decode stage with a two-entry elastic buffer (output + skid).
// Splits an instruction word into opcode/register/immediate fields, extends
// the immediate per opcode, flags illegal opcodes, and counts deliveries.
//
// state   | meaning
// --------+-------------------------------------------------
// S_EMPTY | nothing stored, out_valid=0, in_ready=1
// S_ONE   | output register holds a word, skid empty
// S_FULL  | output and skid both hold words, in_ready=0

module idec_pipe #(
    parameter int OPW  = 4,
    parameter int RAW  = 3,
    parameter int IMMW = 8,
    parameter int DW   = 16,
    parameter logic [2**OPW-1:0] SEXT_MASK    = '0,
    parameter logic [2**OPW-1:0] ILLEGAL_MASK = '0,
    localparam int IW = OPW + 3*RAW + IMMW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   pm_cont,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OPW-1:0]  opcode,
    output logic [RAW-1:0]  op1,
    output logic [RAW-1:0]  op2,
    output logic [RAW-1:0]  op3,
    output logic [IMMW-1:0] data,
    output logic [DW-1:0]   imm,
    output logic            illegal,
    output logic [15:0]     dec_count
);

    typedef struct packed {
        logic [OPW-1:0]  opcode;
        logic [RAW-1:0]  op1;
        logic [RAW-1:0]  op2;
        logic [RAW-1:0]  op3;
        logic [IMMW-1:0] data;
        logic [DW-1:0]   imm;
        logic            illegal;
    } dec_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    dec_t        out_q, out_d;
    dec_t        skid_q, skid_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;
    logic [15:0] dec_count_q, dec_count_d;

    dec_t        dec_in;
    logic        sign_bit;
    logic        in_xfer;
    logic        out_xfer;

    // Decode the incoming word; imm is filled with the sign (or zero) first,
    // then the raw field overwrites the low bits, which also covers DW == IMMW.
    always_comb begin
        dec_in        = '0;
        dec_in.opcode = pm_cont[IW-1 -: OPW];
        dec_in.op1    = pm_cont[IW-OPW-1 -: RAW];
        dec_in.op2    = pm_cont[IW-OPW-RAW-1 -: RAW];
        dec_in.op3    = pm_cont[IMMW+RAW-1 -: RAW];
        dec_in.data   = pm_cont[IMMW-1:0];
        sign_bit      = SEXT_MASK[dec_in.opcode] & dec_in.data[IMMW-1];
        dec_in.imm    = {DW{sign_bit}};
        dec_in.imm[IMMW-1:0] = dec_in.data;
        dec_in.illegal = ILLEGAL_MASK[dec_in.opcode];
    end

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    // Next-state, storage moves and registered handshake flags.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        skid_d      = skid_q;
        dec_count_d = dec_count_q;

        if (out_xfer) begin
            dec_count_d = dec_count_q + 16'd1;
        end

        unique case (state_q)
            S_EMPTY: begin
                if (in_xfer) begin
                    out_d   = dec_in;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (in_xfer && out_xfer) begin
                    out_d = dec_in;
                end else if (in_xfer) begin
                    skid_d  = dec_in;
                    state_d = S_FULL;
                end else if (out_xfer) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (out_xfer) begin
                    out_d   = skid_q;
                    state_d = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        // Flush drops both entries and any word offered this cycle, but a
        // delivery happening in the same cycle has already been counted.
        if (flush) begin
            state_d = S_EMPTY;
        end

        out_valid_d = (state_d != S_EMPTY);
        in_ready_d  = (state_d != S_FULL);
    end

    // State, storage and counter registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            dec_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            dec_count_q <= dec_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign opcode    = out_q.opcode;
    assign op1       = out_q.op1;
    assign op2       = out_q.op2;
    assign op3       = out_q.op3;
    assign data      = out_q.data;
    assign imm       = out_q.imm;
    assign illegal   = out_q.illegal;
    assign dec_count = dec_count_q;

endmodule

// File: tb/tb_idec_pipe.sv
// Self-checking bench for idec_pipe: a queue-based reference of the two-entry
// buffer is compared every cycle, plus literal checks of key scenarios.

module tb_idec_pipe;

    localparam logic [15:0] SEXT = 16'h0020;
    localparam logic [15:0] ILL  = 16'h8000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [20:0] pm_cont = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  opcode;
    logic [2:0]  op1, op2, op3;
    logic [7:0]  data;
    logic [15:0] imm;
    logic        illegal;
    logic [15:0] dec_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int opcode;
        int op1;
        int op2;
        int op3;
        int data;
        int imm;
        int illegal;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_count = 16'd0;
    logic [15:0] base_cnt;

    idec_pipe #(
        .SEXT_MASK(SEXT),
        .ILLEGAL_MASK(ILL)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .pm_cont(pm_cont),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .op1(op1), .op2(op2), .op3(op3),
        .data(data), .imm(imm), .illegal(illegal), .dec_count(dec_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_decode(input int w);
        exp_t e;
        int sx;
        e.opcode  = w / (1 << 17);
        e.op1     = (w / (1 << 14)) % 8;
        e.op2     = (w / (1 << 11)) % 8;
        e.op3     = (w / (1 << 8)) % 8;
        e.data    = w % 256;
        sx        = (int'(SEXT) >> e.opcode) % 2;
        e.imm     = e.data + ((sx == 1 && e.data >= 128) ? 65280 : 0);
        e.illegal = (int'(ILL) >> e.opcode) % 2;
        return e;
    endfunction

    function automatic logic [20:0] mk(input int op, input int a, input int b,
                                       input int c, input int d);
        return 21'((op << 17) + (a << 14) + (b << 11) + (c << 8) + d);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: at most two words in flight, FIFO order, flush empties it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_count = 16'd0;
        end else begin
            bit ox, ix;
            ox = out_ready && (q.size() > 0);
            ix = in_valid && (q.size() < 2);
            if (ox) begin
                void'(q.pop_front());
                m_count = m_count + 16'd1;
            end
            if (flush) q.delete();
            else if (ix) q.push_back(model_decode(int'(pm_cont)));
        end
    end

    // Per-cycle comparison against the reference.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("dec_count", 32'(dec_count), 32'(m_count));
            if (q.size() > 0) begin
                chk("opcode", 32'(opcode), q[0].opcode);
                chk("op1", 32'(op1), q[0].op1);
                chk("op2", 32'(op2), q[0].op2);
                chk("op3", 32'(op3), q[0].op3);
                chk("data", 32'(data), q[0].data);
                chk("imm", 32'(imm), q[0].imm);
                chk("illegal", 32'(illegal), q[0].illegal);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_dec_count", 32'(dec_count), 32'd0);
        chk("rst_fields", {opcode, op1, op2, op3, data}, 32'd0);
        chk("rst_imm_ill", {imm, 15'd0, illegal}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic decode, latency 1
        out_ready = 1'b1;
        in_valid  = 1'b1;
        pm_cont   = 21'b010101000110000000010;
        tick();
        in_valid = 1'b0;
        chk("b_valid", 32'(out_valid), 32'd1);
        chk("b_opcode", 32'(opcode), 32'd5);
        chk("b_op1", 32'(op1), 32'd2);
        chk("b_op2", 32'(op2), 32'd1);
        chk("b_op3", 32'(op3), 32'd4);
        chk("b_data", 32'(data), 32'h02);
        chk("b_imm", 32'(imm), 32'h0002);
        tick();
        chk("b_count", 32'(dec_count), 32'd1);

        // Sign vs zero extension
        in_valid = 1'b1;
        pm_cont  = mk(5, 0, 0, 0, 8'h82);
        tick();
        chk("sext_imm", 32'(imm), 32'hFF82);
        pm_cont = mk(4, 0, 0, 0, 8'h82);
        tick();
        chk("zext_imm", 32'(imm), 32'h0082);
        in_valid = 1'b0;
        tick();

        // Illegal opcode passes through
        in_valid = 1'b1;
        pm_cont  = mk(15, 1, 2, 3, 8'h55);
        tick();
        in_valid = 1'b0;
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_valid", 32'(out_valid), 32'd1);
        tick();
        chk("ill_count", 32'(dec_count), 32'd4);

        // Backpressure: two accepted, third held
        base_cnt  = dec_count;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        pm_cont   = mk(1, 0, 0, 0, 8'h02);
        tick();
        pm_cont = mk(1, 0, 0, 0, 8'h0A);
        tick();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        pm_cont = mk(1, 0, 0, 0, 8'h0B);
        tick();
        tick();
        chk("bp_hold_data", 32'(data), 32'h02);
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_second", 32'(data), 32'h0A);
        tick();
        in_valid = 1'b0;
        chk("bp_third", 32'(data), 32'h0B);
        tick();
        chk("bp_count", 32'(dec_count - base_cnt), 32'd3);
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Flush from FULL with a word offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        pm_cont   = mk(2, 1, 1, 1, 8'h11);
        tick();
        pm_cont = mk(2, 1, 1, 1, 8'h22);
        tick();
        chk("fl_full", 32'(in_ready), 32'd0);
        base_cnt = dec_count;
        flush    = 1'b1;
        pm_cont  = mk(2, 1, 1, 1, 8'h33);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        chk("fl_count", 32'(dec_count), 32'(base_cnt));

        // Asynchronous reset while FULL
        in_valid = 1'b1;
        pm_cont  = mk(3, 2, 2, 2, 8'h44);
        tick();
        pm_cont = mk(3, 2, 2, 2, 8'h45);
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd1);
        chk("ar_count", 32'(dec_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // First accept after reset
        out_ready = 1'b1;
        in_valid  = 1'b1;
        pm_cont   = mk(6, 7, 6, 5, 8'h99);
        tick();
        in_valid = 1'b0;
        chk("pr_data", 32'(data), 32'h99);
        chk("pr_op3", 32'(op3), 32'd5);
        tick();

        // Mixed traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            pm_cont   = 21'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
